// File: rtl/float_pkg.sv
// Shared single-precision float definitions for the adder datapath, plus the
// normalizer's state and packing-kind encodings.
package float_pkg;

    localparam int FRACTION_BITS = 23;
    localparam int EXPONENT_BITS = 8;
    localparam int CNT_BITS      = $clog2(FRACTION_BITS + 1);

    typedef logic [EXPONENT_BITS-1:0] exp_t;
    typedef logic [FRACTION_BITS:0]   sig_t;
    typedef logic [CNT_BITS-1:0]      cnt_t;

    typedef struct packed {
        logic                     sign;
        logic [EXPONENT_BITS-1:0] exp;
        logic [FRACTION_BITS-1:0] frac;
    } float;

    typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} norm_state_t;

    // Which value the packer emits: the working fields, or a special value.
    typedef enum logic [1:0] {PK_NORMAL, PK_ZERO, PK_INF, PK_UNF} pack_kind_t;

    localparam exp_t EXP_MAX     = '1;
    localparam float FP_POS_ZERO = '0;

    function automatic float fp_inf(input logic sign);
        float f;
        f.sign = sign;
        f.exp  = EXP_MAX;
        f.frac = '0;
        return f;
    endfunction

endpackage

// File: rtl/fp_normalize_seq_if.sv
// Operand-in / result-out handshake bundle of the sequential normalizer.
interface fp_normalize_seq_if;
    import float_pkg::*;

    logic in_valid;
    logic in_ready;
    logic in_sign;
    exp_t in_exp;
    logic in_carry;
    sig_t in_sum;
    logic out_valid;
    logic out_ready;
    float result;
    logic zero_flag;
    logic ovf_flag;
    logic unf_flag;

    modport slave (
        input  in_valid, in_sign, in_exp, in_carry, in_sum, out_ready,
        output in_ready, out_valid, result, zero_flag, ovf_flag, unf_flag
    );

    modport master (
        output in_valid, in_sign, in_exp, in_carry, in_sum, out_ready,
        input  in_ready, out_valid, result, zero_flag, ovf_flag, unf_flag
    );
endinterface

// File: rtl/fp_pack_result.sv
// Packs sign/exponent/fraction into a float, or substitutes a special value
// together with its flag.
module fp_pack_result
    import float_pkg::*;
(
    input  logic                     sign,
    input  exp_t                     exp,
    input  logic [FRACTION_BITS-1:0] frac,
    input  pack_kind_t               kind,
    output float                     result,
    output logic                     zero_flag,
    output logic                     ovf_flag,
    output logic                     unf_flag
);
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        result    = '{sign: sign, exp: exp, frac: frac};
        zero_flag = 1'b0;
        ovf_flag  = 1'b0;
        unf_flag  = 1'b0;
        case (kind)
            PK_ZERO: begin
                result    = FP_POS_ZERO;
                zero_flag = 1'b1;
            end
            PK_INF: begin
                result   = fp_inf(sign);
                ovf_flag = 1'b1;
            end
            PK_UNF: begin
                result   = FP_POS_ZERO;
                unf_flag = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/fp_normalize_seq.sv
// Iterative post-addition normalizer: one bit of left shift per clock,
// truncating, flush-to-zero on underflow, saturate-to-infinity on overflow.
module fp_normalize_seq
    import float_pkg::*;
(
    input logic                clk,
    input logic                reset,
    fp_normalize_seq_if.slave  bus
);
    norm_state_t state_q, state_d;
    logic        sign_q,  sign_d;
    exp_t        exp_q,   exp_d;
    logic        carry_q, carry_d;
    sig_t        sum_q,   sum_d;
    cnt_t        cnt_q,   cnt_d;
    float        result_q, result_d;
    logic        zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;

    pack_kind_t               pk_kind;
    exp_t                     pk_exp;
    logic [FRACTION_BITS-1:0] pk_frac;
    float                     pk_result;
    logic                     pk_zero, pk_ovf, pk_unf;
    logic                     go_done;
    sig_t                     sum_sh, carry_sum;
    exp_t                     exp_inc, exp_dec;

    fp_pack_result u_pack (
        .sign      (sign_q),
        .exp       (pk_exp),
        .frac      (pk_frac),
        .kind      (pk_kind),
        .result    (pk_result),
        .zero_flag (pk_zero),
        .ovf_flag  (pk_ovf),
        .unf_flag  (pk_unf)
    );

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        pk_kind  = PK_NORMAL;
        pk_exp   = exp_q;
        pk_frac  = sum_q[FRACTION_BITS-1:0];
        go_done  = 1'b0;

        sum_sh    = {sum_q[FRACTION_BITS-1:0], 1'b0};
        carry_sum = {1'b1, sum_q[FRACTION_BITS:1]};
        exp_inc   = exp_q + exp_t'(1);
        exp_dec   = exp_q - exp_t'(1);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    exp_d   = bus.in_exp;
                    carry_d = bus.in_carry;
                    sum_d   = bus.in_sum;
                    cnt_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (exp_q == '0 || {carry_q, sum_q} == '0) begin
                    pk_kind = PK_ZERO;
                    go_done = 1'b1;
                end else if (exp_q == EXP_MAX) begin
                    pk_kind = PK_INF;
                    go_done = 1'b1;
                end else if (carry_q) begin
                    sum_d   = carry_sum;
                    exp_d   = exp_inc;
                    pk_exp  = exp_inc;
                    pk_frac = carry_sum[FRACTION_BITS-1:0];
                    pk_kind = (exp_inc == EXP_MAX) ? PK_INF : PK_NORMAL;
                    go_done = 1'b1;
                end else if (sum_q[FRACTION_BITS]) begin
                    go_done = 1'b1;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Stop before a shift would take the exponent to zero.
                if (exp_q == exp_t'(1)) begin
                    pk_kind = PK_UNF;
                    go_done = 1'b1;
                end else begin
                    sum_d   = sum_sh;
                    exp_d   = exp_dec;
                    cnt_d   = cnt_q + cnt_t'(1);
                    pk_exp  = exp_dec;
                    pk_frac = sum_sh[FRACTION_BITS-1:0];
                    if (sum_sh[FRACTION_BITS]) begin
                        go_done = 1'b1;
                    end else if (exp_dec == exp_t'(1)) begin
                        pk_kind = PK_UNF;
                        go_done = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_done) begin
            state_d  = DONE;
            result_d = pk_result;
            zero_d   = pk_zero;
            ovf_d    = pk_ovf;
            unf_d    = pk_unf;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cnt_q    <= '0;
            result_q <= FP_POS_ZERO;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero_flag = zero_q;
    assign bus.ovf_flag  = ovf_q;
    assign bus.unf_flag  = unf_q;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Directed bench for fp_normalize_seq: expected results are queued at issue
// time and compared when the result handshake completes.
module tb_fp_normalize_seq;
    import float_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [2:0]  flags;   // {zero, ovf, unf}
        int          cyc;
    } exp_rec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_normalize_seq_if bus ();

    fp_normalize_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_rec_t sb[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Queue the expectation, then present the operand from IDLE; it is
    // accepted at the next rising edge and the inputs are scrambled after.
    task automatic issue(input string tag, input logic s, input exp_t e, input logic c,
                         input sig_t su, input logic [31:0] res, input logic [2:0] flags,
                         input int cyc);
        exp_rec_t r;
        r.tag = tag; r.res = res; r.flags = flags; r.cyc = cyc;
        sb.push_back(r);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_carry = c;
        bus.in_sum   = su;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sign  = 1'($urandom);
        bus.in_exp   = exp_t'($urandom);
        bus.in_carry = 1'($urandom);
        bus.in_sum   = sig_t'($urandom);
    endtask

    // Wait for out_valid, compare against the scoreboard head, optionally
    // stall with out_ready low, then complete the handshake.
    // Cycle numbering: the accept edge is cycle 0; the reported cycle is the
    // edge at which the downstream first samples out_valid high.
    task automatic collect(input int stall);
        exp_rec_t r;
        int k;
        logic [31:0] held;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        r = sb.pop_front();
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (bus.out_valid !== 1'b1) begin
            chk({r.tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
            return;
        end
        chk({r.tag, "_cycle"},  32'(k + 1), 32'(r.cyc));
        chk({r.tag, "_result"}, bus.result, r.res);
        chk({r.tag, "_flags"},  32'({bus.zero_flag, bus.ovf_flag, bus.unf_flag}), 32'(r.flags));
        chk({r.tag, "_busy"},   32'(bus.in_ready), 32'd0);
        held = bus.result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({r.tag, "_stall_valid"},  32'(bus.out_valid), 32'd1);
            chk({r.tag, "_stall_result"}, bus.result, held);
            chk({r.tag, "_stall_ready"},  32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({r.tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
        chk({r.tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
        chk({r.tag, "_flags_clr"},  32'({bus.zero_flag, bus.ovf_flag, bus.unf_flag}), 32'd0);
    endtask

    initial begin
        int seen_valid;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_carry  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    bus.result,         32'h0);
        chk("rst_flags",     32'({bus.zero_flag, bus.ovf_flag, bus.unf_flag}), 32'd0);

        issue("add_5p3",   1'b0, 8'd129, 1'b1, 24'h000000, 32'h41000000, 3'b000, 2);  collect(0);
        issue("sub_5m3",   1'b0, 8'd129, 1'b0, 24'h400000, 32'h40000000, 3'b000, 3);  collect(0);
        issue("neg_5p2",   1'b1, 8'd129, 1'b0, 24'h600000, 32'hC0400000, 3'b000, 3);  collect(0);
        issue("cancel",    1'b1, 8'd129, 1'b0, 24'h000000, 32'h00000000, 3'b100, 2);  collect(0);
        issue("overflow",  1'b0, 8'd254, 1'b1, 24'h800000, 32'h7F800000, 3'b010, 2);  collect(0);
        issue("underflow", 1'b0, 8'd3,   1'b0, 24'h000001, 32'h00000000, 3'b001, 4);  collect(0);
        issue("backpress", 1'b0, 8'd127, 1'b0, 24'hC00000, 32'h3FC00000, 3'b000, 2);  collect(5);
        issue("exp_zero",  1'b1, 8'd0,   1'b0, 24'h800000, 32'h00000000, 3'b100, 2);  collect(0);
        issue("exp_max",   1'b1, 8'hFF,  1'b0, 24'h800000, 32'hFF800000, 3'b010, 2);  collect(0);
        issue("carry_254", 1'b0, 8'd253, 1'b1, 24'hFFFFFF, 32'h7F7FFFFF, 3'b000, 2);  collect(0);
        issue("to_exp1",   1'b0, 8'd2,   1'b0, 24'h400000, 32'h00800000, 3'b000, 3);  collect(0);
        issue("at_exp1",   1'b1, 8'd1,   1'b0, 24'h400000, 32'h00000000, 3'b001, 3);  collect(0);
        issue("max_shift", 1'b0, 8'd100, 1'b0, 24'h000001, 32'h26800000, 3'b000, 25); collect(0);

        // Reset while the underflow operand is mid-SHIFT: nothing may emerge.
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 8'd3;
        bus.in_carry = 1'b0;
        bus.in_sum   = 24'h000001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_in_ready_after", 32'(bus.in_ready),  32'd1);
        chk("midrst_out_valid",      32'(bus.out_valid), 32'd0);
        chk("midrst_result",         bus.result,         32'h0);
        chk("midrst_flags",          32'({bus.zero_flag, bus.ovf_flag, bus.unf_flag}), 32'd0);
        seen_valid = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen_valid++;
        end
        bus.out_ready = 1'b0;
        chk("midrst_no_emit", 32'(seen_valid), 32'd0);

        issue("recover", 1'b0, 8'd129, 1'b1, 24'h000000, 32'h41000000, 3'b000, 2); collect(0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
